// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - decode result type and decode/dispatch queue interface
package decode_queue_pkg;
  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } decode_result_t;
endpackage

interface decode_queue_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
);
  import decode_queue_pkg::*;

  decode_result_t [1:0] in_decoded;
  logic                 in_ready;
  decode_result_t [1:0] out_decoded;
  logic [1:0]           out_accept;
  logic [PTR_W:0]       count;

  modport master (
    output in_decoded, out_accept,
    input  in_ready, out_decoded, count
  );

  modport slave (
    input  in_decoded, out_accept,
    output in_ready, out_decoded, count
  );
endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - two-wide in-order decode-to-dispatch queue
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  decode_queue_if.slave  q
);

  localparam logic [PTR_W:0] ROOM2 = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] ONE   = (PTR_W+1)'(1);

  decode_result_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic push0, push1, pop0, pop1;
  logic [PTR_W:0] n_push, n_pop;
  decode_result_t out0, out1;
  decode_result_t push1_data;

  // in_ready looks only at the registered count, never at this cycle's pops
  assign q.in_ready = (count <= ROOM2);
  assign q.count    = count;

  assign push0  = q.in_ready & q.in_decoded[0].is_valid;
  assign push1  = q.in_ready & q.in_decoded[1].is_valid;
  assign n_push = (PTR_W+1)'(push0) + (PTR_W+1)'(push1);

  always_comb begin
    out0 = '0;
    out1 = '0;
    if (count != '0) begin
      out0          = mem[rd_ptr];
      out0.is_valid = 1'b1;
    end
    if (count > ONE) begin
      out1          = mem[rd_ptr + PTR_W'(1)];
      out1.is_valid = 1'b1;
    end
  end

  assign q.out_decoded[0] = out0;
  assign q.out_decoded[1] = out1;

  // slot 1 can only retire together with slot 0
  assign pop0  = out0.is_valid & q.out_accept[0];
  assign pop1  = pop0 & out1.is_valid & q.out_accept[1];
  assign n_pop = (PTR_W+1)'(pop0) + (PTR_W+1)'(pop1);

  assign push1_data = q.in_decoded[1];

  // lone slot-1 input is compacted down to wr_ptr
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push0) begin
        mem[wr_ptr] <= q.in_decoded[0];
      end
      if (push1) begin
        mem[wr_ptr + PTR_W'(push0)] <= push1_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + n_pop[PTR_W-1:0];
      wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
      count  <= count + n_push - n_pop;
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count <= (PTR_W+1)'(DEPTH));

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_cmp  = 0;
  int   n_fail = 0;

  decode_queue_if #(.DEPTH(8)) dq_if ();

  decode_queue #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (dq_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v0, input logic [31:0] pc0,
                        input logic v1, input logic [31:0] pc1);
    dq_if.in_decoded[0].is_valid = v0;
    dq_if.in_decoded[0].pc       = pc0;
    dq_if.in_decoded[0].inst     = ~pc0;
    dq_if.in_decoded[1].is_valid = v1;
    dq_if.in_decoded[1].pc       = pc1;
    dq_if.in_decoded[1].inst     = ~pc1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    dq_if.out_accept = 2'b00;
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("reset_count", 32'(dq_if.count), 32'd0);
    chk("reset_in_ready", 32'(dq_if.in_ready), 32'd1);
    chk("reset_out0_valid", 32'(dq_if.out_decoded[0].is_valid), 32'd0);
    chk("reset_out1_valid", 32'(dq_if.out_decoded[1].is_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    set_in(1'b1, 32'h100, 1'b1, 32'h104);
    step();
    chk("first_count", 32'(dq_if.count), 32'd2);
    chk("first_out0_pc", dq_if.out_decoded[0].pc, 32'h100);
    chk("first_out1_pc", dq_if.out_decoded[1].pc, 32'h104);
    chk("first_out0_valid", 32'(dq_if.out_decoded[0].is_valid), 32'd1);
    chk("first_out1_valid", 32'(dq_if.out_decoded[1].is_valid), 32'd1);
    chk("first_in_ready", 32'(dq_if.in_ready), 32'd1);
    chk("first_out0_inst", dq_if.out_decoded[0].inst, ~32'h100);

    set_in(1'b1, 32'h108, 1'b1, 32'h10c);
    step();
    set_in(1'b1, 32'h110, 1'b1, 32'h114);
    step();
    chk("fill6_in_ready", 32'(dq_if.in_ready), 32'd1);
    set_in(1'b1, 32'h118, 1'b0, 32'h0);
    step();
    chk("fill7_count", 32'(dq_if.count), 32'd7);
    chk("fill7_in_ready", 32'(dq_if.in_ready), 32'd0);
    set_in(1'b1, 32'h120, 1'b1, 32'h124);
    step();
    chk("full_ignored_count", 32'(dq_if.count), 32'd7);
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    dq_if.out_accept = 2'b01;
    step();
    chk("accept1_count", 32'(dq_if.count), 32'd6);
    chk("accept1_in_ready", 32'(dq_if.in_ready), 32'd1);
    chk("accept1_out0_pc", dq_if.out_decoded[0].pc, 32'h104);

    dq_if.out_accept = 2'b11;
    step();
    step();
    step();
    chk("drain_count", 32'(dq_if.count), 32'd0);

    dq_if.out_accept = 2'b00;
    set_in(1'b1, 32'h200, 1'b1, 32'h204);
    step();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    dq_if.out_accept = 2'b10;
    step();
    chk("inorder_count", 32'(dq_if.count), 32'd2);
    chk("inorder_out0_pc", dq_if.out_decoded[0].pc, 32'h200);
    dq_if.out_accept = 2'b11;
    step();
    chk("both_pop_count", 32'(dq_if.count), 32'd0);
    chk("both_pop_out0_valid", 32'(dq_if.out_decoded[0].is_valid), 32'd0);
    chk("both_pop_out1_valid", 32'(dq_if.out_decoded[1].is_valid), 32'd0);

    dq_if.out_accept = 2'b00;
    set_in(1'b0, 32'h0, 1'b1, 32'h300);
    step();
    chk("compact_count", 32'(dq_if.count), 32'd1);
    chk("compact_out0_pc", dq_if.out_decoded[0].pc, 32'h300);
    chk("compact_out0_valid", 32'(dq_if.out_decoded[0].is_valid), 32'd1);
    chk("compact_out1_valid", 32'(dq_if.out_decoded[1].is_valid), 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    dq_if.out_accept = 2'b11;
    step();
    chk("compact_drain_count", 32'(dq_if.count), 32'd0);

    dq_if.out_accept = 2'b00;
    set_in(1'b1, 32'h400, 1'b1, 32'h404);
    step();
    dq_if.out_accept = 2'b11;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h408 + 32'(8 * i), 1'b1, 32'h40c + 32'(8 * i));
      step();
      chk("wrap_out0_pc", dq_if.out_decoded[0].pc, 32'h408 + 32'(8 * i));
      chk("wrap_out1_pc", dq_if.out_decoded[1].pc, 32'h40c + 32'(8 * i));
      chk("wrap_count", 32'(dq_if.count), 32'd2);
    end

    dq_if.out_accept = 2'b00;
    set_in(1'b1, 32'h500, 1'b1, 32'h504);
    step();
    set_in(1'b1, 32'h508, 1'b0, 32'h0);
    step();
    chk("preflush_count", 32'(dq_if.count), 32'd5);
    set_in(1'b1, 32'h600, 1'b1, 32'h604);
    dq_if.out_accept = 2'b11;
    flush = 1'b1;
    step();
    chk("flush_count", 32'(dq_if.count), 32'd0);
    chk("flush_out0_valid", 32'(dq_if.out_decoded[0].is_valid), 32'd0);
    chk("flush_out1_valid", 32'(dq_if.out_decoded[1].is_valid), 32'd0);
    chk("flush_in_ready", 32'(dq_if.in_ready), 32'd1);
    flush = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    dq_if.out_accept = 2'b00;
    step();
    chk("postflush_count", 32'(dq_if.count), 32'd0);

    set_in(1'b1, 32'h700, 1'b1, 32'h704);
    step();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("prereset_count", 32'(dq_if.count), 32'd2);
    reset = 1'b1;
    #1;
    chk("async_reset_count", 32'(dq_if.count), 32'd0);
    chk("async_reset_out0_valid", 32'(dq_if.out_decoded[0].is_valid), 32'd0);
    chk("async_reset_out1_valid", 32'(dq_if.out_decoded[1].is_valid), 32'd0);
    chk("async_reset_in_ready", 32'(dq_if.in_ready), 32'd1);
    #1 reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
